// File: rtl/dl_router.sv
// rtl/dl_router.sv - routes ioctl downloads to toggle-handshake memory ports, DIP bytes and core_mod
// Also sequences the game-core reset once the ROM download has finished.
module dl_router #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W = 25,
  parameter logic [NUM_PORTS*ADDR_W-1:0] PORT_BASE = {25'h30000, 25'h0},
  parameter logic [NUM_PORTS*ADDR_W-1:0] PORT_LIMIT = {25'h1FFFFFF, 25'h1FFFFFF},
  parameter int RST_W = 16,
  parameter logic [RST_W-1:0] RST_HOLD = 16'hFFFF,
  parameter int DIP_BYTES = 8,
  parameter logic [7:0] IDX_ROM = 8'd0,
  parameter logic [7:0] IDX_MOD = 8'd1,
  parameter logic [7:0] IDX_DIP = 8'd254
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          ioctl_download,
  input  logic [7:0]                    ioctl_index,
  input  logic                          ioctl_wr,
  input  logic [ADDR_W-1:0]             ioctl_addr,
  input  logic [7:0]                    ioctl_dout,
  output logic                          ioctl_wait,
  input  logic                          user_reset,
  output logic [NUM_PORTS-1:0]          port_req,
  input  logic [NUM_PORTS-1:0]          port_ack,
  output logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
  output logic [NUM_PORTS*2-1:0]        port_ds,
  output logic [15:0]                   port_d,
  output logic                          port_we,
  output logic [DIP_BYTES*8-1:0]        dip_sw,
  output logic [7:0]                    core_mod,
  output logic                          rom_loaded,
  output logic                          core_reset,
  output logic                          overrun
);

  logic [NUM_PORTS-1:0]        port_req_q, port_req_d;
  logic [NUM_PORTS*ADDR_W-1:0] port_addr_q, port_addr_d;
  logic [NUM_PORTS*2-1:0]      port_ds_q, port_ds_d;
  logic [15:0]                 port_d_q, port_d_d;
  logic                        port_we_q, port_we_d;
  logic                        wr_last_q, wr_last_d;
  logic                        dl_d_q, dl_d_d;
  logic [DIP_BYTES*8-1:0]      dip_sw_q, dip_sw_d;
  logic [7:0]                  core_mod_q, core_mod_d;
  logic                        rom_loaded_q, rom_loaded_d;
  logic                        overrun_q, overrun_d;
  logic [RST_W-1:0]            cnt_q, cnt_d;
  logic                        core_reset_q, core_reset_d;

  logic                        rom_dl;
  logic                        wr_evt;
  logic                        any_upd;
  logic [NUM_PORTS-1:0]        pending;
  logic [NUM_PORTS-1:0]        hit;

  assign ioctl_wait = |pending;
  assign port_req   = port_req_q;
  assign port_addr  = port_addr_q;
  assign port_ds    = port_ds_q;
  assign port_d     = port_d_q;
  assign port_we    = port_we_q;
  assign dip_sw     = dip_sw_q;
  assign core_mod   = core_mod_q;
  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;
  assign overrun    = overrun_q;

  always_comb begin
    rom_dl       = ioctl_download && (ioctl_index == IDX_ROM);
    wr_evt       = ioctl_wr && !wr_last_q;
    pending      = port_req_q ^ port_ack;
    hit          = '0;
    any_upd      = 1'b0;
    port_req_d   = port_req_q;
    port_addr_d  = port_addr_q;
    port_ds_d    = port_ds_q;
    port_d_d     = port_d_q;
    overrun_d    = overrun_q;
    dip_sw_d     = dip_sw_q;
    core_mod_d   = core_mod_q;
    rom_loaded_d = rom_loaded_q;
    cnt_d        = cnt_q;
    port_we_d    = rom_dl;
    wr_last_d    = ioctl_wr;
    dl_d_d       = rom_dl;
    core_reset_d = (cnt_q != '0);

    // Windows may overlap; a busy port flags overrun without blocking the others.
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit[i] = (ioctl_addr >= PORT_BASE[i*ADDR_W +: ADDR_W]) &&
               (ioctl_addr <= PORT_LIMIT[i*ADDR_W +: ADDR_W]);
      if (wr_evt && rom_dl && hit[i]) begin
        if (pending[i]) begin
          overrun_d = 1'b1;
        end else begin
          port_req_d[i]                  = ~port_req_q[i];
          port_addr_d[i*ADDR_W +: ADDR_W] = ioctl_addr - PORT_BASE[i*ADDR_W +: ADDR_W];
          port_ds_d[i*2 +: 2]            = {ioctl_addr[0], ~ioctl_addr[0]};
          any_upd                        = 1'b1;
        end
      end
    end
    if (any_upd) begin
      port_d_d = {ioctl_dout, ioctl_dout};
    end

    if (ioctl_wr && (ioctl_index == IDX_MOD)) begin
      core_mod_d = ioctl_dout;
    end
    for (int k = 0; k < DIP_BYTES; k++) begin
      if (ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr == ADDR_W'(k))) begin
        dip_sw_d[k*8 +: 8] = ioctl_dout;
      end
    end

    if (dl_d_q && !rom_dl) begin
      rom_loaded_d = 1'b1;
    end
    if (user_reset || !rom_loaded_q) begin
      cnt_d = RST_HOLD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - RST_W'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      port_req_q   <= '0;
      port_addr_q  <= '0;
      port_ds_q    <= '0;
      port_d_q     <= '0;
      port_we_q    <= 1'b0;
      wr_last_q    <= 1'b0;
      dl_d_q       <= 1'b0;
      dip_sw_q     <= '0;
      core_mod_q   <= '0;
      rom_loaded_q <= 1'b0;
      overrun_q    <= 1'b0;
      cnt_q        <= RST_HOLD;
      core_reset_q <= 1'b1;
    end else begin
      port_req_q   <= port_req_d;
      port_addr_q  <= port_addr_d;
      port_ds_q    <= port_ds_d;
      port_d_q     <= port_d_d;
      port_we_q    <= port_we_d;
      wr_last_q    <= wr_last_d;
      dl_d_q       <= dl_d_d;
      dip_sw_q     <= dip_sw_d;
      core_mod_q   <= core_mod_d;
      rom_loaded_q <= rom_loaded_d;
      overrun_q    <= overrun_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

endmodule

// File: tb/tb_dl_router.sv
// tb/tb_dl_router.sv - scoreboard bench for dl_router with a queue-based reference model
module tb_dl_router;
  localparam int H = 4;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        user_reset = 1'b0;
  logic [1:0]  port_req;
  logic [1:0]  port_ack = 2'b00;
  logic [49:0] port_addr;
  logic [3:0]  port_ds;
  logic [15:0] port_d;
  logic        port_we;
  logic [63:0] dip_sw;
  logic [7:0]  core_mod;
  logic        rom_loaded;
  logic        core_reset;
  logic        overrun;

  always #5 clk_sys = ~clk_sys;

  dl_router #(.RST_HOLD(16'd4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .user_reset(user_reset),
    .port_req(port_req), .port_ack(port_ack), .port_addr(port_addr),
    .port_ds(port_ds), .port_d(port_d), .port_we(port_we), .dip_sw(dip_sw),
    .core_mod(core_mod), .rom_loaded(rom_loaded), .core_reset(core_reset),
    .overrun(overrun)
  );

  typedef struct {
    logic [24:0] addr;
    logic [1:0]  ds;
    logic [15:0] d;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [24:0] win_base[2] = '{25'h0, 25'h30000};
  logic [24:0] win_lim[2]  = '{25'h1FFFFFF, 25'h1FFFFFF};
  bit          outst[2];
  bit          m_ov, m_loaded, m_wr_prev, m_dl_prev, sink_en;
  logic [7:0]  m_mod;
  logic [7:0]  m_dip[8];
  int          m_k;
  int          errors = 0;
  int          checks = 0;
  logic [1:0]  prev_req = 2'b00;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    outst = '{0, 0};
    m_ov = 0; m_loaded = 0; m_wr_prev = 0; m_dl_prev = 0;
    m_mod = 8'h00; m_k = 0;
    for (int b = 0; b < 8; b++) m_dip[b] = 8'h00;
  endtask

  task automatic cycle(input bit rst, input bit dl, input logic [7:0] idx, input bit wr,
                       input logic [24:0] addr, input logic [7:0] dout, input bit ur,
                       input logic [1:0] ack_t);
    logic [1:0] tg;
    bit         rom_dl, hold;
    exp_t       e;
    @(negedge clk_sys);
    tg = ack_t;
    if (sink_en)
      for (int i = 0; i < 2; i++)
        if (port_req[i] != port_ack[i] && $urandom_range(0, 3) == 0) tg[i] = 1'b1;
    reset = rst; ioctl_download = dl; ioctl_index = idx; ioctl_wr = wr;
    ioctl_addr = addr; ioctl_dout = dout; user_reset = ur;
    if (rst) begin
      port_ack = 2'b00;
      model_reset();
    end else begin
      port_ack = port_ack ^ tg;
      for (int i = 0; i < 2; i++) if (tg[i]) outst[i] = 0;
      rom_dl = dl && (idx == 8'd0);
      if (wr && !m_wr_prev && rom_dl) begin
        for (int i = 0; i < 2; i++) begin
          if (addr >= win_base[i] && addr <= win_lim[i]) begin
            if (outst[i]) m_ov = 1;
            else begin
              e.addr = addr - win_base[i];
              e.ds = addr[0] ? 2'b10 : 2'b01;
              e.d = {dout, dout};
              if (i == 0) q0.push_back(e); else q1.push_back(e);
              outst[i] = 1;
            end
          end
        end
      end
      if (wr && idx == 8'd1) m_mod = dout;
      if (wr && idx == 8'd254 && addr < 25'd8) m_dip[addr[2:0]] = dout;
      hold = ur || !m_loaded;
      if (m_dl_prev && !rom_dl) m_loaded = 1;
      m_k = hold ? 0 : m_k + 1;
      m_dl_prev = rom_dl;
      m_wr_prev = wr;
    end
  endtask

  // Monitor: pops an expected port write whenever a request toggles, checks sticky state each clock.
  always @(posedge clk_sys) begin
    exp_t        e;
    logic [63:0] dflat;
    #1;
    if (reset) begin
      chk("rst_port_req", port_req, 0);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_rom_loaded", rom_loaded, 0);
      chk("rst_dip_sw", dip_sw, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_ioctl_wait", ioctl_wait, 0);
      prev_req = 2'b00;
    end else begin
      if (port_req[0] != prev_req[0]) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL p0_toggle: actual=toggled required=no toggle");
        end else begin
          e = q0.pop_front();
          chk("p0_addr", port_addr[24:0], e.addr);
          chk("p0_ds", port_ds[1:0], e.ds);
          chk("p0_data", port_d, e.d);
        end
      end
      if (port_req[1] != prev_req[1]) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL p1_toggle: actual=toggled required=no toggle");
        end else begin
          e = q1.pop_front();
          chk("p1_addr", port_addr[49:25], e.addr);
          chk("p1_ds", port_ds[3:2], e.ds);
          chk("p1_data", port_d, e.d);
        end
      end
      prev_req = port_req;
      for (int b = 0; b < 8; b++) dflat[b*8 +: 8] = m_dip[b];
      chk("ioctl_wait", ioctl_wait, outst[0] | outst[1]);
      chk("overrun", overrun, m_ov);
      chk("core_mod", core_mod, m_mod);
      chk("dip_sw", dip_sw, dflat);
      chk("rom_loaded", rom_loaded, m_loaded);
      if (m_k >= 1) chk("core_reset", core_reset, (m_k <= H) ? 1 : 0);
    end
  end

  initial begin
    bit          dl, wr, ur;
    logic [7:0]  idx, dout;
    logic [24:0] addr;
    logic [24:0] edges[4] = '{25'h0, 25'h2FFFF, 25'h30000, 25'h1FFFFFF};
    int          r, drain;
    sink_en = 0;
    model_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // DIP byte 3, ignored DIP byte 8, core_mod
    cycle(0, 0, 8'd254, 1, 25'd3, 8'h5C, 0, 0);
    cycle(0, 0, 8'd254, 0, 25'd3, 8'h5C, 0, 0);
    cycle(0, 0, 8'd254, 1, 25'd8, 8'hFF, 0, 0);
    cycle(0, 0, 8'd254, 0, 25'd8, 8'hFF, 0, 0);
    cycle(0, 0, 8'd1, 1, 25'd0, 8'h0B, 0, 0);
    cycle(0, 0, 8'd1, 0, 25'd0, 8'h0B, 0, 0);
    // ROM write hitting both windows, then both acks
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 25'h30005, 8'hA5, 0, 0);
    cycle(0, 1, 0, 0, 25'h30005, 8'hA5, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 2'b11);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    // Overrun on port 1 while port 0 has been acknowledged
    cycle(0, 1, 0, 1, 25'h30005, 8'h11, 0, 0);
    cycle(0, 1, 0, 0, 25'h30005, 8'h11, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 2'b01);
    cycle(0, 1, 0, 1, 25'h30006, 8'h22, 0, 0);
    cycle(0, 1, 0, 0, 25'h30006, 8'h22, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 2'b11);
    // End download, let core_reset release, then a user_reset pulse
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 9; c++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 9; c++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // Reset in the middle of a download
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 25'h10, 8'h33, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 7; c++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // Randomized traffic with a randomly stalling sink
    sink_en = 1;
    dl = 0; wr = 0; idx = 0; addr = 0; dout = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) dl = !dl;
      ur = ($urandom_range(0, 59) == 0);
      if (wr) begin
        wr = ($urandom_range(0, 2) == 0);
      end else begin
        r = $urandom_range(0, 9);
        dout = 8'($urandom);
        addr = ($urandom_range(0, 1) == 0) ? edges[$urandom_range(0, 3)]
                                           : 25'($urandom_range(0, 32'h3FFFF));
        wr = (r <= 7);
        if (r <= 4) idx = 8'd0;
        else if (r == 5) idx = 8'd5;
        else if (r == 6) idx = 8'd1;
        else begin
          idx = 8'd254;
          addr = 25'($urandom_range(0, 9));
        end
      end
      cycle(0, dl, idx, wr, addr, dout, ur, 0);
    end
    drain = 0;
    while ((q0.size() != 0 || q1.size() != 0 || outst[0] || outst[1]) && drain < 100) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      drain++;
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk_sys);
    #2;
    chk("drain_q0_empty", q0.size(), 0);
    chk("drain_q1_empty", q1.size(), 0);
    chk("drain_ioctl_wait", ioctl_wait, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
